matrix_mem_resp: RTL

Responder side of the matrix-memory read interface consumed by the Gauss-Seidel iteration engine. Holds a 1024 x 256-bit matrix store and accepts address/read-request handshakes. Returns each row in order with a fixed, parameterised latency and a one-cycle valid strobe. A back-door write port lets the bench or a host preload matrices. An optional LFSR-driven stall exercises the requester's `i_mem_rrdy` handling.

---
 rtl/matrix_mem_resp_pkg.sv | 18 +
 rtl/matrix_mem_resp_if.sv | 24 ++
 rtl/matrix_mem_resp_sram.sv | 26 ++
 rtl/matrix_mem_resp.sv | 95 +++++++++
 4 files changed

// File: rtl/matrix_mem_resp_pkg.sv
// Shared widths, types and stall-LFSR helpers for the matrix-memory read responder.
package matrix_mem_resp_pkg;

    localparam int unsigned MEM_AW    = 10;
    localparam int unsigned MEM_DW    = 256;
    localparam int unsigned MEM_DEPTH = 1 << MEM_AW;

    // Fibonacci taps 8,6,5,4 (1-indexed) as a bit mask on the 8-bit state.
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    typedef logic [MEM_AW-1:0] mem_addr_t;
    typedef logic [MEM_DW-1:0] mem_data_t;

    function automatic logic [7:0] lfsr_next(input logic [7:0] state);
        return {state[6:0], ^(state & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/matrix_mem_resp_if.sv
// Read handshake plus back-door write port between a requester/host and the responder.
interface matrix_mem_resp_if;
    import matrix_mem_resp_pkg::*;

    logic      i_mem_rreq;
    mem_addr_t i_mem_addr;
    logic      o_mem_rrdy;
    mem_data_t o_mem_dout;
    logic      o_mem_dout_vld;
    logic      i_wen;
    mem_addr_t i_waddr;
    mem_data_t i_wdata;

    modport master (
        output i_mem_rreq, i_mem_addr, i_wen, i_waddr, i_wdata,
        input  o_mem_rrdy, o_mem_dout, o_mem_dout_vld
    );

    modport slave (
        input  i_mem_rreq, i_mem_addr, i_wen, i_waddr, i_wdata,
        output o_mem_rrdy, o_mem_dout, o_mem_dout_vld
    );

endinterface

// File: rtl/matrix_mem_resp_sram.sv
// matrix_sram: 1024x256 single-clock 1R1W array, registered read, read-before-write, no reset.
module matrix_mem_resp_sram
    import matrix_mem_resp_pkg::*;
(
    input  logic      clk,
    input  logic      ren,
    input  mem_addr_t raddr,
    output mem_data_t rdata,
    input  logic      wen,
    input  mem_addr_t waddr,
    input  mem_data_t wdata
);

    mem_data_t mem_q [MEM_DEPTH];

    // Both updates are non-blocking, so a same-edge read of the written row sees old data.
    always_ff @(posedge clk) begin
        if (wen) begin
            mem_q[waddr] <= wdata;
        end
        if (ren) begin
            rdata <= mem_q[raddr];
        end
    end

endmodule

// File: rtl/matrix_mem_resp.sv
// Matrix-memory read responder: fixed-latency in-order row returns, outstanding-read
// throttling and optional pseudo-random stall of the ready signal.
module matrix_mem_resp
    import matrix_mem_resp_pkg::*;
#(
    parameter int unsigned LATENCY   = 2,
    parameter int unsigned MAX_OUT   = 2,
    parameter bit          STALL_EN  = 1'b0,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input logic              i_clk,
    input logic              i_reset,
    matrix_mem_resp_if.slave mem
);

    localparam int unsigned CNT_W = 3;
    typedef logic [CNT_W-1:0] cnt_t;

    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("matrix_mem_resp: LATENCY must be 1..4");
    end
    if (MAX_OUT < 1 || MAX_OUT > 4) begin : g_bad_max_out
        $error("matrix_mem_resp: MAX_OUT must be 1..4");
    end

    logic               accept;
    logic               stall;
    logic               dout_vld;
    logic [7:0]         lfsr_q;
    cnt_t               out_cnt_q;
    cnt_t               out_cnt_d;
    logic [LATENCY-1:0] vld_q;
    mem_data_t          sram_rdata;
    mem_data_t          pipe_data;

    matrix_mem_resp_sram u_sram (
        .clk   (i_clk),
        .ren   (accept),
        .raddr (mem.i_mem_addr),
        .rdata (sram_rdata),
        .wen   (mem.i_wen),
        .waddr (mem.i_waddr),
        .wdata (mem.i_wdata)
    );

    assign stall          = STALL_EN && (lfsr_q[1:0] == 2'b00);
    assign mem.o_mem_rrdy = !i_reset && (out_cnt_q < cnt_t'(MAX_OUT)) && !stall;
    assign accept         = mem.i_mem_rreq && mem.o_mem_rrdy;

    assign dout_vld           = vld_q[LATENCY-1];
    assign mem.o_mem_dout_vld = dout_vld;
    assign mem.o_mem_dout     = dout_vld ? pipe_data : '0;

    // A slot is freed only in the cycle its data is presented.
    always_comb begin
        out_cnt_d = out_cnt_q;
        unique case ({accept, dout_vld})
            2'b10:   out_cnt_d = out_cnt_q + cnt_t'(1);
            2'b01:   out_cnt_d = out_cnt_q - cnt_t'(1);
            default: out_cnt_d = out_cnt_q;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            lfsr_q    <= LFSR_SEED;
            out_cnt_q <= '0;
            vld_q     <= '0;
        end else begin
            lfsr_q    <= lfsr_next(lfsr_q);
            out_cnt_q <= out_cnt_d;
            vld_q[0]  <= accept;
            for (int i = 1; i < int'(LATENCY); i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // The SRAM read register is the first data stage; later stages carry no reset.
    if (LATENCY == 1) begin : g_lat1
        assign pipe_data = sram_rdata;
    end else begin : g_latn
        mem_data_t data_q [LATENCY-1];

        always_ff @(posedge i_clk) begin
            data_q[0] <= sram_rdata;
            for (int i = 1; i < int'(LATENCY) - 1; i++) begin
                data_q[i] <= data_q[i-1];
            end
        end

        assign pipe_data = data_q[LATENCY-2];
    end

endmodule
